// File: rtl/mult_rr_arbiter.sv
// Two-requester round-robin front end for a shared N_SLOTS-lane vector multiplier.
// The lane products are captured in one output register tagged with the
// requester id. That register can hold its value while downstream is stalled.
module mult_rr_arbiter #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned W_BITS  = 8,
    parameter int unsigned CNT_W   = 16,
    parameter bit          RR_INIT = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req0_valid,
    output logic                                 req0_ready,
    input  logic [N_SLOTS*W_BITS-1:0]            req0_a,
    input  logic [N_SLOTS*W_BITS-1:0]            req0_b,
    input  logic                                 req1_valid,
    output logic                                 req1_ready,
    input  logic [N_SLOTS*W_BITS-1:0]            req1_a,
    input  logic [N_SLOTS*W_BITS-1:0]            req1_b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [N_SLOTS*(2*W_BITS+1)-1:0]      out_data,
    output logic                                 out_id,
    output logic [CNT_W-1:0]                     grant_cnt0,
    output logic [CNT_W-1:0]                     grant_cnt1
);

    localparam int unsigned LANE_W = 2 * W_BITS + 1;
    localparam int unsigned VEC_W  = N_SLOTS * W_BITS;
    localparam int unsigned WIDE_W = N_SLOTS * LANE_W;

    logic              last_grant;
    logic              can_accept;
    logic              g0;
    logic              g1;
    logic              xfer0;
    logic              xfer1;
    logic [VEC_W-1:0]  sel_a;
    logic [VEC_W-1:0]  sel_b;
    logic [WIDE_W-1:0] prod;

    // The output slot is free when it is empty or is being drained this cycle.
    assign can_accept = !out_valid || out_ready;

    // Round-robin grant: when both ports request, the port that was not granted last wins.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (req0_valid && req1_valid) begin
            g0 = last_grant;
            g1 = !last_grant;
        end else begin
            g0 = req0_valid;
            g1 = req1_valid;
        end
    end

    assign req0_ready = g0 && can_accept && !reset;
    assign req1_ready = g1 && can_accept && !reset;
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;

    // Steer the granted operands into the shared multiplier. Each lane is independent and zero-extended.
    always_comb begin
        sel_a = g1 ? req1_a : req0_a;
        sel_b = g1 ? req1_b : req0_b;
        prod  = '0;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            prod[i*LANE_W +: LANE_W] = LANE_W'(sel_a[i*W_BITS +: W_BITS])
                                     * LANE_W'(sel_b[i*W_BITS +: W_BITS]);
        end
    end

    // Output register, round-robin pointer and saturating grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= 1'b0;
            last_grant <= RR_INIT;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (xfer0 || xfer1) begin
            out_valid  <= 1'b1;
            out_data   <= prod;
            out_id     <= xfer1;
            last_grant <= xfer1;
            if (xfer0 && (grant_cnt0 != {CNT_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (xfer1 && (grant_cnt1 != {CNT_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Scoreboard bench for mult_rr_arbiter: the reference model predicts grants and products,
// and a monitor checks every product that leaves the output stage.
module tb_mult_rr_arbiter;

    localparam int unsigned NS = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned LW = 2 * W + 1;
    localparam int unsigned VW = NS * W;
    localparam int unsigned WW = NS * LW;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [WW-1:0] data;
        logic          id;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [VW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          out_valid, out_ready, out_id;
    logic [WW-1:0] out_data;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    logic          d2_req1_valid, d2_req0_ready, d2_req1_ready, d2_out_valid, d2_out_id;
    logic [WW-1:0] d2_out_data;
    logic [1:0]    d2_cnt0, d2_cnt1;
    logic [VW-1:0] zero_vec;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mult_rr_arbiter #(.N_SLOTS(NS), .W_BITS(W), .CNT_W(CW), .RR_INIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    mult_rr_arbiter #(.N_SLOTS(NS), .W_BITS(W), .CNT_W(2), .RR_INIT(1'b1)) dut2 (
        .clk(clk), .reset(reset),
        .req0_valid(1'b0), .req0_ready(d2_req0_ready), .req0_a(zero_vec), .req0_b(zero_vec),
        .req1_valid(d2_req1_valid), .req1_ready(d2_req1_ready), .req1_a(zero_vec), .req1_b(zero_vec),
        .out_valid(d2_out_valid), .out_ready(1'b1), .out_data(d2_out_data), .out_id(d2_out_id),
        .grant_cnt0(d2_cnt0), .grant_cnt1(d2_cnt1)
    );

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Same value placed in every lane.
    function automatic logic [WW-1:0] lanes_of(input longint unsigned v);
        logic [WW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NS); i++) r[i*LW +: LW] = LW'(v);
        return r;
    endfunction

    // Reference lane products computed with plain integer arithmetic.
    function automatic logic [WW-1:0] ref_mul(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [WW-1:0]     r;
        longint unsigned   x, y;
        r = '0;
        for (int i = 0; i < int'(NS); i++) begin
            x = longint'(a[i*W +: W]);
            y = longint'(b[i*W +: W]);
            r[i*LW +: LW] = LW'(x * y);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < int'(NS); i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    // Reference model: predicts readiness, the output occupancy and the counters, and queues expected products.
    int    m_last = 1;
    bit    m_full = 1'b0;
    int    m_cnt0 = 0;
    int    m_cnt1 = 0;
    always @(negedge clk) begin
        int g;
        bit can, e0, e1;
        check("out_valid", WW'(out_valid), WW'(m_full));
        check("grant_cnt0", WW'(grant_cnt0), WW'(m_cnt0));
        check("grant_cnt1", WW'(grant_cnt1), WW'(m_cnt1));
        if (reset) begin
            check("ready_in_reset", WW'({req1_ready, req0_ready}), WW'(0));
            m_last = 1;
            m_full = 1'b0;
            m_cnt0 = 0;
            m_cnt1 = 0;
            sb.delete();
        end else begin
            g = -1;
            if (req0_valid && req1_valid) g = 1 - m_last;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
            can = !m_full || out_ready;
            e0  = (g == 0) && can;
            e1  = (g == 1) && can;
            check("ready", WW'({req1_ready, req0_ready}), WW'({e1, e0}));
            if (e0 || e1) begin
                sb.push_back('{data: (e1 ? ref_mul(req1_a, req1_b) : ref_mul(req0_a, req0_b)), id: e1});
                m_last = g;
                m_full = 1'b1;
                if (e0 && m_cnt0 < (1 << CW) - 1) m_cnt0++;
                if (e1 && m_cnt1 < (1 << CW) - 1) m_cnt1++;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks that stalled output is stable.
    bit            stalled = 1'b0;
    logic [WW-1:0] held_data;
    logic          held_id;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) begin
                check("stall_data", out_data, held_data);
                check("stall_id", WW'(out_id), WW'(held_id));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got id %0d data %0h expected none", out_id, out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_id", WW'(out_id), WW'(e.id));
                end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_id   = out_id;
        end
    end

    initial begin
        bit            acc0, acc1;
        logic [VW-1:0] v;
        zero_vec      = '0;
        reset         = 1'b1;
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        out_ready     = 1'b0;
        d2_req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single requester, every lane 3*3.
        for (int i = 0; i < int'(NS); i++) v[i*W +: W] = W'(3);
        req0_valid = 1'b1; req0_a = v; req0_b = v; out_ready = 1'b1;
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("t1_lanes_9", out_data, lanes_of(9));
        check("t1_id", WW'(out_id), WW'(0));
        check("t1_cnt0", WW'(grant_cnt0), WW'(1));

        // Back-to-back contention with the output draining every cycle.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = rand_vec(); req0_b = rand_vec();
        req1_valid = 1'b1; req1_a = rand_vec(); req1_b = rand_vec();
        repeat (4) @(posedge clk);
        // Output stalled for three cycles while both keep requesting.
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Lane extremes: all-ones operands, then a single non-zero lane.
        #1 req0_valid = 1'b1; req0_a = '1; req0_b = '1;
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("t4_max_lanes", out_data, lanes_of((longint'(1) << (2*W)) - (longint'(1) << (W+1)) + 1));
        @(posedge clk); #1;
        req1_a = '0; req1_b = '0;
        req1_a[2*W +: W] = W'(5); req1_b[2*W +: W] = W'(7);
        req1_valid = 1'b1;
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        v = '0;
        check("t4_single_lane", out_data, WW'(35) << (2*LW));
        check("t4_id", WW'(out_id), WW'(1));

        // Reset while the output is full and both ports request.
        @(posedge clk); #1;
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_a = rand_vec(); req0_b = rand_vec();
        req1_valid = 1'b1; req1_a = rand_vec(); req1_b = rand_vec();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("t5_post_reset_port0", WW'({req1_ready, req0_ready}), WW'(2'b01));
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;

        // Random traffic; requesters hold operands until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a = rand_vec(); req0_b = rand_vec();
                if ($urandom_range(0, 7) == 0) req0_a = '1;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = rand_vec(); req1_b = rand_vec();
                if ($urandom_range(0, 7) == 0) req1_b = '1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end

        // Drain.
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", WW'(sb.size()), WW'(0));

        // Two-bit counters saturate.
        @(posedge clk); #1 d2_req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_cnt1_two", WW'(d2_cnt1), WW'(2));
        repeat (3) @(posedge clk);
        #1 d2_req1_valid = 1'b0;
        @(negedge clk);
        check("t6_cnt1_sat", WW'(d2_cnt1), WW'(3));
        check("t6_cnt0_zero", WW'(d2_cnt0), WW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
